dbus_arbiter: RTL and testbench
===============================

DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter c_TIMEOUTWIDTH, default 16: width of the per-transfer timeout counter.
REQ-002 Port i_clock  input  1  sole clock; all state SHALL be on its rising edge.
REQ-003 Port i_reset  input  1  asynchronous, active-high reset.
REQ-004 Port i_req0  input  1  requester 0 has a byte pending (level).
REQ-005 Port i_data0  input  8  requester 0 byte.
REQ-006 Port o_ack0  output  1  one-cycle pulse: requester 0 byte taken.
REQ-007 Port i_req1  input  1  requester 1 has a byte pending (level).
REQ-008 Port i_data1  input  8  requester 1 byte.
REQ-009 Port o_ack1  output  1  one-cycle pulse: requester 1 byte taken.
REQ-010 Port i_busy  input  1  dbus transmitter busy.
REQ-011 Port o_data  output  8  byte presented to dbus; stable while o_enable is high.
REQ-012 Port o_enable  output  1  dbus send request (level).
REQ-013 Port o_grant  output  1  index of the last granted requester.
REQ-014 Port o_timeout  output  1  sticky error flag.

Function
REQ-015 i_busy SHALL be registered once (busy_q) before use; no other input is registered.
REQ-016 FSM states SHALL be IDLE, ISSUE and DRAIN.
REQ-017 IDLE, any request, busy_q low: capture the winner's byte into o_data, set o_grant, pulse the winner's ack and raise o_enable on the next cycle, then enter ISSUE.
REQ-018 Arbitration SHALL be round-robin: when both requests are asserted, the requester not equal to o_grant wins; a single request wins unconditionally.
REQ-019 IDLE with busy_q high SHALL grant nothing.
REQ-020 ISSUE: o_enable high; on busy_q high, drop o_enable and enter DRAIN.
REQ-021 DRAIN: o_enable low; on busy_q low, enter IDLE.
REQ-022 Minimum spacing between two acks SHALL be 4 cycles.
REQ-023 o_ack0 and o_ack1 SHALL never be high in the same cycle.
REQ-024 A request deasserted after its ack SHALL NOT affect the transfer in flight.
REQ-025 Requests arriving outside IDLE SHALL wait; none are lost while held.

Reset
REQ-026 Reset SHALL force: state IDLE, o_enable 0, o_ack0/1 0, o_data 0x00, o_grant 1 (requester 0 first), o_timeout 0, busy_q 1, counter 0.
REQ-027 Reset mid-transfer SHALL drop o_enable asynchronously and discard the captured byte.

Configuration
REQ-028 With DBUS_ARB_TIMEOUT_EN defined: the counter clears on entry to ISSUE or DRAIN and increments each cycle there.
REQ-029 On saturation (2^c_TIMEOUTWIDTH-1) the FSM SHALL return to IDLE with o_enable 0, drop the byte and set o_timeout until reset.
REQ-030 Without DBUS_ARB_TIMEOUT_EN: no counter, o_timeout tied 0, ISSUE/DRAIN wait indefinitely.

Structure
REQ-031 State encodings (IDLE=0, ISSUE=1, DRAIN=2) and the byte width (8) SHALL live in shared package dbus_pkg.
REQ-032 Round-robin selection SHALL be sub-module rr_arbiter_2 (inputs: 2 requests, last grant; outputs: valid, winner).

Verification
REQ-033 Reset, i_req0=1 with 0xA5, i_busy pulses high 3 cycles after o_enable -> o_ack0 one pulse, o_data=0xA5, o_enable falls the cycle after busy_q rises, back to IDLE.
REQ-034 Both requests held (0x11/0x22), busy modelled as 5 cycles per byte -> dbus sees 0x11,0x22,0x11,0x22; acks alternate starting with 0.
REQ-035 i_busy held high, i_req1=1 -> no ack, o_enable 0; release i_busy -> o_ack1 within 2 cycles.
REQ-036 DBUS_ARB_TIMEOUT_EN, c_TIMEOUTWIDTH=4, i_busy stuck low after grant -> o_timeout set 15 cycles after ISSUE entry, o_enable 0, next request still served.
REQ-037 Reset asserted while in DRAIN with i_req0=1 -> o_enable 0 immediately; after release, requester 0 is re-granted.

Source files
------------

// File: rtl/dbus_pkg.sv
// dbus_pkg -- shared definitions for the dbus arbiter slice.
//   BYTE_W        : width of one dbus byte
//   dbus_byte_t   : one dbus byte
//   dbus_state_e  : arbiter FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2)
package dbus_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] dbus_byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } dbus_state_e;

endpackage

// File: rtl/dbus_arbiter_rr.sv
// rr_arbiter_2 -- two-way round-robin selector, purely combinational.
//   req0_i, req1_i : request levels
//   last_i         : index of the most recently granted requester
//   valid_o        : at least one request present
//   winner_o       : index of the requester to serve
// With both requests present the requester that was not served last wins;
// a lone request always wins.
module rr_arbiter_2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic valid_o,
  output logic winner_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      winner_o = ~last_i;
    end else begin
      winner_o = req1_i;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter -- arbitrates two byte requesters onto a single dbus
// transmitter.
//   i_clock            : sole clock, rising edge
//   i_reset            : asynchronous active-high reset
//   i_req0 / i_data0   : requester 0 pending level and byte
//   o_ack0             : one-cycle pulse, requester 0 byte taken
//   i_req1 / i_data1   : requester 1 pending level and byte
//   o_ack1             : one-cycle pulse, requester 1 byte taken
//   i_busy             : dbus transmitter busy (registered once internally)
//   o_data             : byte presented to dbus, stable while o_enable high
//   o_enable           : dbus send request level
//   o_grant            : index of the last granted requester
//   o_timeout          : sticky transfer-timeout flag
//   o_state            : current FSM state (debug visibility)
// Optional feature: define DBUS_ARB_TIMEOUT_EN to enable the per-transfer
// timeout counter of width c_TIMEOUTWIDTH.
//
// Handshakes: a requester holds i_reqN high with a stable i_dataN until it
// sees o_ackN; the byte is captured in the ack cycle, so the request may
// drop afterwards without disturbing the transfer. Towards the dbus,
// o_enable is held with a stable o_data until the transmitter reports busy;
// the next byte is offered only after busy has dropped again.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned c_TIMEOUTWIDTH = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic [BYTE_W-1:0] i_data0,
  output logic              o_ack0,
  input  logic              i_req1,
  input  logic [BYTE_W-1:0] i_data1,
  output logic              o_ack1,
  input  logic              i_busy,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_enable,
  output logic              o_grant,
  output logic              o_timeout,
  output logic [1:0]        o_state
);

  dbus_state_e state_q, state_d;
  dbus_byte_t  data_q, data_d;
  logic        busy_q;
  logic        grant_q, grant_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        enable_q, enable_d;
  logic        arb_valid, arb_winner;

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam logic [c_TIMEOUTWIDTH-1:0] CNT_MAX = '1;
  logic [c_TIMEOUTWIDTH-1:0] cnt_q, cnt_d;
  logic                      timeout_q, timeout_d;
`endif

  rr_arbiter_2 u_rr (
    .req0_i   (i_req0),
    .req1_i   (i_req1),
    .last_i   (grant_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    grant_d  = grant_q;
    enable_d = enable_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
`ifdef DBUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (arb_valid && !busy_q) begin
          data_d   = arb_winner ? i_data1 : i_data0;
          grant_d  = arb_winner;
          ack0_d   = ~arb_winner;
          ack1_d   = arb_winner;
          enable_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        enable_d = 1'b1;
        // busy_q seen during the ack cycle predates this byte's o_enable,
        // so it is ignored; this also keeps acks at least 4 cycles apart.
        if (busy_q && !(ack0_q || ack1_q)) begin
          enable_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        enable_d = 1'b0;
        if (!busy_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        enable_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

`ifdef DBUS_ARB_TIMEOUT_EN
    if (state_q == ISSUE || state_q == DRAIN) begin
      if (cnt_q == CNT_MAX - 1'b1) begin
        // Counter saturates on this edge: abandon the transfer.
        cnt_d     = CNT_MAX;
        timeout_d = 1'b1;
        enable_d  = 1'b0;
        data_d    = '0;
        state_d   = IDLE;
      end else if (state_d != state_q) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Held at zero in IDLE so entry into ISSUE starts from a clear count.
      cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b1;
      data_q   <= '0;
      grant_q  <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= i_busy;
      data_q   <= data_d;
      grant_q  <= grant_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      enable_q <= enable_d;
    end
  end

`ifdef DBUS_ARB_TIMEOUT_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  // Without the counter the width parameter has no role.
  logic unused_timeout_w;
  assign unused_timeout_w = ^c_TIMEOUTWIDTH;
  assign o_timeout        = 1'b0;
`endif

  assign o_ack0   = ack0_q;
  assign o_ack1   = ack1_q;
  assign o_data   = data_q;
  assign o_enable = enable_q;
  assign o_grant  = grant_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter -- directed self-checking bench for dbus_arbiter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dbus_arbiter;
  import dbus_pkg::*;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       i_req0 = 1'b0;
  logic [7:0] i_data0 = 8'h00;
  logic       o_ack0;
  logic       i_req1 = 1'b0;
  logic [7:0] i_data1 = 8'h00;
  logic       o_ack1;
  logic       i_busy = 1'b0;
  logic [7:0] o_data;
  logic       o_enable;
  logic       o_grant;
  logic       o_timeout;
  logic [1:0] o_state;

  int n_cmp = 0;
  int n_fail = 0;

  // ack monitor
  int cyc = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int both_hi = 0;
  int gap_viol = 0;
  int last_ack = -100;

  logic [7:0] exp_q[$];

  dbus_arbiter #(.c_TIMEOUTWIDTH(4)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_req0    (i_req0),
    .i_data0   (i_data0),
    .o_ack0    (o_ack0),
    .i_req1    (i_req1),
    .i_data1   (i_data1),
    .o_ack1    (o_ack1),
    .i_busy    (i_busy),
    .o_data    (o_data),
    .o_enable  (o_enable),
    .o_grant   (o_grant),
    .o_timeout (o_timeout),
    .o_state   (o_state)
  );

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_ack = -100;
    end else begin
      if (o_ack0 && o_ack1) both_hi++;
      if (o_ack0) ack0_cnt++;
      if (o_ack1) ack1_cnt++;
      if (o_ack0 || o_ack1) begin
        if (cyc - last_ack < 4) gap_viol++;
        last_ack = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    i_req0 = 1'b0; i_req1 = 1'b0; i_busy = 1'b0;
    i_data0 = 8'h00; i_data1 = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic busy_pulse();
    i_busy = 1'b1;
    repeat (2) @(negedge clk);
    i_busy = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (o_state !== 2'd0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (o_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s_idle: state %0d, required 0", name, o_state);
    end
  endtask

  // tests
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (o_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %b want 0", o_enable); end
    n_cmp++; if (o_ack0 !== 1'b0 || o_ack1 !== 1'b0) begin n_fail++; $display("FAIL rst_acks: got %b%b want 00", o_ack0, o_ack1); end
    n_cmp++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", o_data); end
    n_cmp++; if (o_grant !== 1'b1) begin n_fail++; $display("FAIL rst_grant: got %b want 1", o_grant); end
    n_cmp++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", o_timeout); end
    n_cmp++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", o_state); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (o_enable !== 1'b0 || o_state !== 2'd0) begin n_fail++; $display("FAIL rst_quiet: enable %b state %0d want 0/0", o_enable, o_state); end
  endtask

  task automatic test_single();
    int a0;
    int a1;
    a0 = ack0_cnt; a1 = ack1_cnt;
    i_data0 = 8'hA5; i_req0 = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_ack0 !== 1'b1 || o_enable !== 1'b1) begin n_fail++; $display("FAIL single_grant: ack0 %b enable %b want 1/1", o_ack0, o_enable); end
    n_cmp++; if (o_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", o_data); end
    n_cmp++; if (o_grant !== 1'b0) begin n_fail++; $display("FAIL single_gnt: got %b want 0", o_grant); end
    i_req0 = 1'b0; i_data0 = 8'h00;
    @(negedge clk);
    n_cmp++; if (o_ack0 !== 1'b0 || o_enable !== 1'b1 || o_data !== 8'hA5) begin n_fail++; $display("FAIL single_hold: ack0 %b enable %b data %h want 0/1/a5", o_ack0, o_enable, o_data); end
    @(negedge clk);
    i_busy = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_enable !== 1'b1) begin n_fail++; $display("FAIL single_en_busyq: got %b want 1", o_enable); end
    @(negedge clk);
    n_cmp++; if (o_enable !== 1'b0 || o_state !== 2'd2) begin n_fail++; $display("FAIL single_drain: enable %b state %0d want 0/2", o_enable, o_state); end
    i_busy = 1'b0;
    wait_idle("single");
    repeat (3) @(negedge clk);
    n_cmp++; if (ack0_cnt - a0 !== 1 || ack1_cnt - a1 !== 0) begin n_fail++; $display("FAIL single_ackcnt: ack0 %0d ack1 %0d want 1/0", ack0_cnt - a0, ack1_cnt - a1); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    logic       exp_a0;
    int         t;
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back((i % 2 == 0) ? 8'h11 : 8'h22);
    i_data0 = 8'h11; i_data1 = 8'h22;
    i_req0 = 1'b1; i_req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (o_enable !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      n_cmp++; if (o_enable !== 1'b1) begin n_fail++; $display("FAIL rr_wait%0d: enable %b want 1", i, o_enable); end
      exp = exp_q.pop_front();
      exp_a0 = ((i % 2) == 0);
      n_cmp++; if (o_data !== exp) begin n_fail++; $display("FAIL rr_data%0d: got %h want %h", i, o_data, exp); end
      n_cmp++; if (o_ack0 !== exp_a0 || o_ack1 !== ~exp_a0) begin n_fail++; $display("FAIL rr_ack%0d: got %b%b want %b%b", i, o_ack0, o_ack1, exp_a0, ~exp_a0); end
      if (i == 3) begin i_req0 = 1'b0; i_req1 = 1'b0; end
      busy_pulse();
    end
    wait_idle("rr");
    n_cmp++; if (gap_viol !== 0) begin n_fail++; $display("FAIL rr_gap: %0d short ack gaps, want 0", gap_viol); end
    n_cmp++; if (both_hi !== 0) begin n_fail++; $display("FAIL rr_both: %0d dual-ack cycles, want 0", both_hi); end
  endtask

  task automatic test_busy_hold();
    logic seen_ack;
    logic seen_en;
    logic seen1;
    i_busy = 1'b1;
    repeat (2) @(negedge clk);
    i_data1 = 8'h5C; i_req1 = 1'b1;
    seen_ack = 1'b0; seen_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_ack0 || o_ack1) seen_ack = 1'b1;
      if (o_enable) seen_en = 1'b1;
    end
    n_cmp++; if (seen_ack !== 1'b0) begin n_fail++; $display("FAIL bh_noack: got %b want 0", seen_ack); end
    n_cmp++; if (seen_en !== 1'b0) begin n_fail++; $display("FAIL bh_noen: got %b want 0", seen_en); end
    i_busy = 1'b0;
    seen1 = 1'b0;
    for (int k = 0; k < 2 && !seen1; k++) begin
      @(negedge clk);
      if (o_ack1) seen1 = 1'b1;
    end
    n_cmp++; if (seen1 !== 1'b1) begin n_fail++; $display("FAIL bh_ack1: seen %b want 1", seen1); end
    n_cmp++; if (o_data !== 8'h5C || o_grant !== 1'b1) begin n_fail++; $display("FAIL bh_data: data %h grant %b want 5c/1", o_data, o_grant); end
    i_req1 = 1'b0;
    busy_pulse();
    wait_idle("bh");
  endtask

  task automatic test_timeout();
    do_reset();
    i_data0 = 8'h3C; i_req0 = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_ack0 !== 1'b1) begin n_fail++; $display("FAIL to_ack: got %b want 1", o_ack0); end
    i_req0 = 1'b0;
    repeat (14) @(negedge clk);
    n_cmp++; if (o_timeout !== 1'b0 || o_enable !== 1'b1) begin n_fail++; $display("FAIL to_early: timeout %b enable %b want 0/1", o_timeout, o_enable); end
    @(negedge clk);
`ifdef DBUS_ARB_TIMEOUT_EN
    n_cmp++; if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b want 1", o_timeout); end
    n_cmp++; if (o_enable !== 1'b0 || o_state !== 2'd0 || o_data !== 8'h00) begin n_fail++; $display("FAIL to_abort: enable %b state %0d data %h want 0/0/00", o_enable, o_state, o_data); end
    begin
      logic seen1;
      i_data1 = 8'h66; i_req1 = 1'b1;
      seen1 = 1'b0;
      for (int k = 0; k < 3 && !seen1; k++) begin
        @(negedge clk);
        if (o_ack1) seen1 = 1'b1;
      end
      n_cmp++; if (seen1 !== 1'b1 || o_data !== 8'h66) begin n_fail++; $display("FAIL to_next: ack1 %b data %h want 1/66", seen1, o_data); end
      i_req1 = 1'b0;
      busy_pulse();
      wait_idle("to");
      n_cmp++; if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", o_timeout); end
    end
`else
    repeat (5) @(negedge clk);
    n_cmp++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL to_tied: got %b want 0", o_timeout); end
    n_cmp++; if (o_enable !== 1'b1 || o_state !== 2'd1) begin n_fail++; $display("FAIL to_wait: enable %b state %0d want 1/1", o_enable, o_state); end
    busy_pulse();
    wait_idle("to");
`endif
  endtask

  task automatic test_reset_mid();
    logic seen0;
    int   t;
    do_reset();
    // reset while in ISSUE: o_enable must fall without a clock edge
    i_data0 = 8'h77; i_req0 = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (o_enable !== 1'b0 || o_data !== 8'h00 || o_state !== 2'd0) begin n_fail++; $display("FAIL rm_issue: enable %b data %h state %0d want 0/00/0", o_enable, o_data, o_state); end
    @(negedge clk);
    rst = 1'b0;
    // re-grant, then park in DRAIN with busy stuck high
    seen0 = 1'b0;
    for (int k = 0; k < 4 && !seen0; k++) begin
      @(negedge clk);
      if (o_ack0) seen0 = 1'b1;
    end
    i_busy = 1'b1;
    t = 0;
    while (o_state !== 2'd2 && t < 6) begin
      @(negedge clk);
      t++;
    end
    n_cmp++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL rm_drain: state %0d want 2", o_state); end
    i_data1 = 8'h99; i_req1 = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (o_enable !== 1'b0 || o_data !== 8'h00 || o_state !== 2'd0 || o_grant !== 1'b1) begin n_fail++; $display("FAIL rm_rst: enable %b data %h state %0d grant %b want 0/00/0/1", o_enable, o_data, o_state, o_grant); end
    @(negedge clk);
    i_busy = 1'b0;
    rst = 1'b0;
    seen0 = 1'b0;
    for (int k = 0; k < 4 && !seen0; k++) begin
      @(negedge clk);
      if (o_ack0) seen0 = 1'b1;
    end
    n_cmp++; if (seen0 !== 1'b1 || o_ack1 !== 1'b0) begin n_fail++; $display("FAIL rm_regrant: ack0 %b ack1 %b want 1/0", seen0, o_ack1); end
    n_cmp++; if (o_grant !== 1'b0 || o_data !== 8'h77) begin n_fail++; $display("FAIL rm_data: grant %b data %h want 0/77", o_grant, o_data); end
    i_req0 = 1'b0; i_req1 = 1'b0;
    busy_pulse();
    wait_idle("rm");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_hold();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
